// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS-lite pipeline: fetch-stage state encoding,
// the bubble instruction and the instruction width in bytes.
package cpu_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } if_state_t;

   localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
   localparam logic [31:0] INSTR_BYTES = 32'd4;

   // Redirect targets may carry junk in the byte-offset bits.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc4, instr} holding register that catches a fetched word
// arriving while the downstream output buffer is frozen.
module if_skid_buf
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        load,
   input  logic        drain,
   input  logic [31:0] pc4_d,
   input  logic [31:0] instr_d,
   output logic        valid,
   output logic [31:0] pc4,
   output logic [31:0] instr
);

   // Clear wins over load so a redirect can never leave a stale word behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         pc4   <= '0;
         instr <= NOP_INSTR;
      end else if (clear) begin
         valid <= 1'b0;
         instr <= NOP_INSTR;
      end else if (load) begin
         valid <= 1'b1;
         pc4   <= pc4_d;
         instr <= instr_d;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to a
// variable-latency instruction memory and feeds IF/ID. IF_FETCH_STATS_EN adds counters.
module if_fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] pc4_o,
   output logic [31:0] instr_o,
   output logic        valid_o
`ifdef IF_FETCH_STATS_EN
   ,
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] bubble_cnt_o
`endif
);

   if_state_t   state, state_d;
   logic [31:0] pc, pc_req;
   logic        rsp, issue, skid_load, skid_drain;
   logic        skid_valid;
   logic [31:0] skid_pc4, skid_instr;
   logic [31:0] pc4_d, instr_d;
   logic        valid_d;

   always_ff @(posedge clk) begin
      if (rst) state <= S_REQ;
      else     state <= state_d;
   end

   // A response arriving with redirect or in S_DROP simply falls through to S_REQ.
   always_comb begin
      state_d = state;
      case (state)
         S_REQ:  if (issue) state_d = S_WAIT;
         S_WAIT: begin
            if (imem_rvalid_i)   state_d = issue ? S_WAIT : S_REQ;
            else if (redirect_i) state_d = S_DROP;
         end
         S_DROP: if (imem_rvalid_i) state_d = S_REQ;
         default: state_d = S_REQ;
      endcase
   end

   // Issue is held off while the skid is occupied or about to be filled.
   always_comb begin
      rsp       = (state == S_WAIT) && imem_rvalid_i;
      skid_load = rsp && !redirect_i && stall_i && valid_o && !skid_valid;
      issue     = !rst && !redirect_i && !skid_valid && !skid_load
                  && ((state == S_REQ) || rsp);
   end

   assign imem_req_o  = issue;
   assign imem_addr_o = pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc     <= RESET_PC;
         pc_req <= RESET_PC;
      end else if (redirect_i) begin
         pc <= word_align(redirect_pc_i);
      end else if (issue) begin
         pc     <= pc + INSTR_BYTES;
         pc_req <= pc;
      end
   end

   if_skid_buf u_skid (
      .clk     (clk),
      .rst     (rst),
      .clear   (redirect_i),
      .load    (skid_load),
      .drain   (skid_drain),
      .pc4_d   (pc_req + INSTR_BYTES),
      .instr_d (imem_rdata_i),
      .valid   (skid_valid),
      .pc4     (skid_pc4),
      .instr   (skid_instr)
   );

   // Source priority: redirect, skid, fresh response, then bubble when not stalled.
   always_comb begin
      pc4_d      = pc4_o;
      instr_d    = instr_o;
      valid_d    = valid_o;
      skid_drain = 1'b0;
      if (redirect_i) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (skid_valid && !stall_i) begin
         pc4_d      = skid_pc4;
         instr_d    = skid_instr;
         valid_d    = 1'b1;
         skid_drain = 1'b1;
      end else if (rsp && !skid_load) begin
         pc4_d   = pc_req + INSTR_BYTES;
         instr_d = imem_rdata_i;
         valid_d = 1'b1;
      end else if (!stall_i) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc4_o   <= '0;
         instr_o <= NOP_INSTR;
         valid_o <= 1'b0;
      end else begin
         pc4_o   <= pc4_d;
         instr_o <= instr_d;
         valid_o <= valid_d;
      end
   end

`ifdef IF_FETCH_STATS_EN
   // Accepted responses exclude those thrown away by a redirect or in S_DROP.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_o  <= '0;
         bubble_cnt_o <= '0;
      end else begin
         if (rsp && !redirect_i)   fetch_cnt_o  <= fetch_cnt_o + 32'd1;
         if (!stall_i && !valid_d) bubble_cnt_o <= bubble_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a behavioural variable-latency memory
// that returns the request address as the instruction word.
module tb_if_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = 32'hDEAD_BEEF;
   logic [31:0] pc4_o;
   logic [31:0] instr_o;
   logic        valid_o;
`ifdef IF_FETCH_STATS_EN
   logic [31:0] fetch_cnt_o;
   logic [31:0] bubble_cnt_o;
`endif

   int          vectors = 0;
   int          miscompares = 0;
   int          mem_lat = 1;
   logic        mem_pend = 1'b0;
   logic [31:0] mem_addr = '0;
   int          mem_rem = 0;

   if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .pc4_o         (pc4_o),
      .instr_o       (instr_o),
      .valid_o       (valid_o)
`ifdef IF_FETCH_STATS_EN
      ,
      .fetch_cnt_o   (fetch_cnt_o),
      .bubble_cnt_o  (bubble_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkBuf(input string tag, input logic [31:0] pc4,
                           input logic [31:0] instr, input logic valid);
      checkOutput({tag, "_pc4"}, pc4_o, pc4);
      checkOutput({tag, "_instr"}, instr_o, instr);
      checkOutput({tag, "_valid"}, {31'd0, valid_o}, {31'd0, valid});
   endtask

   task automatic applyStimulus(input logic stall, input logic redirect,
                                input logic [31:0] rpc, input logic reset);
      stall_i       = stall;
      redirect_i    = redirect;
      redirect_pc_i = rpc;
      rst           = reset;
      #1;
   endtask

   // One clock: sample the request, cross the edge, then update the memory model.
   task automatic stepClock();
      logic        req_seen;
      logic        rst_seen;
      logic [31:0] addr_seen;
      req_seen  = imem_req_o;
      addr_seen = imem_addr_o;
      rst_seen  = rst;
      @(posedge clk);
      #1;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'hDEAD_BEEF;
      if (rst_seen) begin
         mem_pend = 1'b0;
      end else if (req_seen) begin
         mem_pend = 1'b1;
         mem_addr = addr_seen;
         mem_rem  = mem_lat;
      end
      if (mem_pend) begin
         if (mem_rem <= 1) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_addr;
            mem_pend      = 1'b0;
         end else begin
            mem_rem--;
         end
      end
      #1;
   endtask

   initial begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      stepClock();
      stepClock();
      checkBuf("reset", 32'h0, 32'h0, 1'b0);
      checkOutput("reset_req", {31'd0, imem_req_o}, 32'd0);
      checkOutput("reset_addr", imem_addr_o, RESET_PC);

      // 1-cycle memory, free running; first word wraps the PC.
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("c0_req", {31'd0, imem_req_o}, 32'd1);
      checkOutput("c0_addr", imem_addr_o, 32'hFFFF_FFFC);
      stepClock();
      checkOutput("c1_valid", {31'd0, valid_o}, 32'd0);
      checkOutput("c1_addr_wrap", imem_addr_o, 32'h0000_0000);
      stepClock();
      checkBuf("w0", 32'h0, 32'hFFFF_FFFC, 1'b1);
      stepClock();
      checkBuf("w1", 32'h4, 32'h0, 1'b1);
`ifdef IF_FETCH_STATS_EN
      checkOutput("fetch_cnt", fetch_cnt_o, 32'd2);
      checkOutput("bubble_cnt", bubble_cnt_o, 32'd1);
`endif
      stepClock();
      checkBuf("w2", 32'h8, 32'h4, 1'b1);

      // 3-cycle memory: bubbles between words.
      mem_lat = 3;
      stepClock();
      checkBuf("w3", 32'hC, 32'h8, 1'b1);
      checkOutput("lat3_wait_req", {31'd0, imem_req_o}, 32'd0);
      stepClock();
      checkBuf("lat3_bubble", 32'hC, 32'h0, 1'b0);
      checkOutput("lat3_wait_req2", {31'd0, imem_req_o}, 32'd0);
      stepClock();
      checkOutput("lat3_rsp_req", {31'd0, imem_req_o}, 32'd1);
      checkOutput("lat3_rsp_addr", imem_addr_o, 32'h10);
      stepClock();
      checkBuf("w4", 32'h10, 32'hC, 1'b1);
      stepClock();
      stepClock();
      checkBuf("lat3_bubble2", 32'h10, 32'h0, 1'b0);
      checkOutput("lat3_rsp_addr2", imem_addr_o, 32'h14);
      mem_lat = 1;
      stepClock();
      checkBuf("w5", 32'h14, 32'h10, 1'b1);

      // Stall four cycles while the 0x14 word arrives: it must go to the skid.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("skid_load_req", {31'd0, imem_req_o}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         stepClock();
         checkBuf("stall_hold", 32'h14, 32'h10, 1'b1);
         checkOutput("stall_req", {31'd0, imem_req_o}, 32'd0);
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("drain_req", {31'd0, imem_req_o}, 32'd0);
      stepClock();
      checkBuf("skid_word", 32'h18, 32'h14, 1'b1);
      checkOutput("post_drain_req", {31'd0, imem_req_o}, 32'd1);
      checkOutput("post_drain_addr", imem_addr_o, 32'h18);
      stepClock();
      checkBuf("post_skid_bubble", 32'h18, 32'h0, 1'b0);
      checkOutput("next_addr", imem_addr_o, 32'h1C);

      // Redirect to 0x100 while the 0x1C fetch is outstanding.
      mem_lat = 3;
      stepClock();
      checkBuf("w6", 32'h1C, 32'h18, 1'b1);
      applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b0);
      checkOutput("redir_req", {31'd0, imem_req_o}, 32'd0);
      stepClock();
      checkOutput("redir_valid", {31'd0, valid_o}, 32'd0);
      checkOutput("redir_instr", instr_o, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("drop_wait_req", {31'd0, imem_req_o}, 32'd0);
      stepClock();
      checkOutput("drop_rsp_req", {31'd0, imem_req_o}, 32'd0);
      stepClock();
      checkOutput("dropped_valid", {31'd0, valid_o}, 32'd0);
      checkOutput("dropped_instr", instr_o, 32'h0);
      checkOutput("redir_fetch_req", {31'd0, imem_req_o}, 32'd1);
      checkOutput("redir_fetch_addr", imem_addr_o, 32'h100);
      mem_lat = 1;
      stepClock();
      checkOutput("redir_gap_valid", {31'd0, valid_o}, 32'd0);
      checkOutput("redir_next_addr", imem_addr_o, 32'h104);
      stepClock();
      checkBuf("redir_word", 32'h104, 32'h100, 1'b1);

      // Misaligned target together with stall: buffer still cleared.
      applyStimulus(1'b1, 1'b1, 32'h0000_0043, 1'b0);
      checkOutput("redir_stall_req", {31'd0, imem_req_o}, 32'd0);
      stepClock();
      checkOutput("redir_stall_valid", {31'd0, valid_o}, 32'd0);
      checkOutput("redir_stall_instr", instr_o, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("aligned_req", {31'd0, imem_req_o}, 32'd1);
      checkOutput("aligned_addr", imem_addr_o, 32'h40);
      stepClock();
      stepClock();
      checkBuf("aligned_word", 32'h44, 32'h40, 1'b1);

      // Reset with a response in flight, then restart from RESET_PC.
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("rst_req", {31'd0, imem_req_o}, 32'd0);
      stepClock();
      checkBuf("reset2", 32'h0, 32'h0, 1'b0);
      checkOutput("reset2_addr", imem_addr_o, RESET_PC);
`ifdef IF_FETCH_STATS_EN
      checkOutput("reset2_fetch_cnt", fetch_cnt_o, 32'd0);
      checkOutput("reset2_bubble_cnt", bubble_cnt_o, 32'd0);
`endif
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("restart_req", {31'd0, imem_req_o}, 32'd1);
      stepClock();
      stepClock();
      checkBuf("restart_word", 32'h0, 32'hFFFF_FFFC, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the pipelined MIPS-lite CPU. Sits directly upstream of the IF/ID pipeline register.
- Owns the PC and issues one-outstanding requests to instruction memory, which has variable latency.
- Buffers each returned word, plus a one-entry skid, and presents PC+4 and the instruction to IF/ID.
- Applies branch/jump redirects from the later stages.
- Inserts NOP bubbles (instruction 0) when no valid word is available.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).

Ports:
clk  in  1  clock, rising-edge.
rst  in  1  synchronous, active-high reset.
stall_i  in  1  hazard-unit freeze; output buffer must hold.
redirect_i  in  1  branch/jump taken this cycle.
redirect_pc_i  in  32  redirect target; bits [1:0] ignored (forced 0).
imem_req_o  out  1  fetch request (combinational from state).
imem_addr_o  out  32  fetch address, word aligned.
imem_rvalid_i  in  1  response valid; at least 1 cycle after request.
imem_rdata_i  in  32  instruction word.
pc4_o  out  32  registered PC+4 of the presented instruction (to IF/ID PCIn).
instr_o  out  32  registered instruction (to IF/ID instructionIn); 0 when bubble.
valid_o  out  1  registered; instr_o holds a real fetched word.

Behaviour:
Reset (rst=1 at clk edge):
- pc=RESET_PC; state=S_REQ.
- instr_o=0, pc4_o=0, valid_o=0; skid empty.
- imem_req_o=0 while rst=1.

State machine:
- S_REQ: request allowed.
- S_WAIT: one request outstanding.
- S_DROP: outstanding response must be discarded.

Request issue:
- Issue condition: imem_req_o=1 when redirect_i=0, skid is empty and will stay empty this cycle, and either state=S_REQ or (state=S_WAIT and imem_rvalid_i=1).
- On issue: imem_addr_o=pc; pc_req<=pc; pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0); next state S_WAIT.
- Back-to-back issue in the response cycle lets a 1-cycle memory sustain 1 instruction/cycle.
- S_WAIT with rvalid and no issue -> S_REQ.

Response routing in S_WAIT when rvalid=1:
- stall_i=0, skid empty: output buffer <= {pc_req+4, rdata, valid=1}.
- stall_i=1, valid_o=1: word goes to skid; output holds; no issue until skid drains.
- stall_i=1, valid_o=0: word loads the output buffer directly.

Output buffer update:
- When stall_i=0 and there is no response or skid source, output becomes a bubble: instr_o=0, valid_o=0, pc4_o held.
- Skid has priority over a same-cycle response. The same-cycle response cannot occur, because issue is blocked while the skid is full.

Redirect (highest priority, overrides stall_i):
- pc<={redirect_pc_i[31:2],2'b00}.
- Output buffer and skid cleared (instr_o=0, valid_o=0).
- If S_WAIT with rvalid=0: -> S_DROP.
- If S_WAIT with rvalid=1: response discarded; -> S_REQ.
- If S_REQ: no request this cycle; remains S_REQ.
- S_DROP + redirect: pc updated, stays S_DROP.

S_DROP: next rvalid is discarded -> S_REQ. No request is issued in that cycle.

Other rules:
- rvalid in S_REQ is a protocol error; ignored.
- Reset mid-request: outstanding response is forgotten. The memory model must be reset together with this block.

Optional Feature:
Macro: IF_FETCH_STATS_EN.
- With it: two extra outputs, fetch_cnt_o[31:0] and bubble_cnt_o[31:0].
  - fetch_cnt_o increments per accepted (non-discarded) response.
  - bubble_cnt_o increments per cycle with stall_i=0 and valid_o=0 after update.
  - Both wrap at 2^32 and reset to 0.
- Without it: ports and counters absent; no other behaviour change.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding typedef if_state_t (S_REQ, S_WAIT, S_DROP);
  - constant NOP_INSTR=32'h0;
  - constant INSTR_BYTES=4.
- One sub-module is natural: if_skid_buf. This is the 1-entry {pc4,instr} holding register with load/drain/clear controls.

Test Plan:
1. Reset then run with 1-cycle memory returning addr as data, stall_i=0 -> first valid_o 2 cycles after reset release; then instr_o=0,4,8,... one per cycle, pc4_o=instr_o+4.
2. 3-cycle memory latency -> imem_req_o every 3 cycles; bubbles (instr_o=0, valid_o=0) between words; fetch order 0,4,8 intact.
3. stall_i held 4 cycles while a response arrives -> instr_o/pc4_o frozen; skid captures the next word; no new request; after release, skid word presented next cycle with no loss or duplicate.
4. redirect_i with redirect_pc_i=32'h0000_0100 while request to 0x8 is outstanding -> next cycle valid_o=0; the 0x8 response is dropped; next request addr=0x100; pc4_o=0x104 when it lands.
5. redirect_pc_i=32'h0000_0043 -> imem_addr_o=0x40; redirect asserted together with stall_i=1 -> buffer still cleared.
6. RESET_PC=32'hFFFF_FFFC -> fetches 0xFFFFFFFC then 0x0; with IF_FETCH_STATS_EN, fetch_cnt_o=2 after both land.
